wrap_in_operands: RTL and testbench
===================================

Name: wrap_in_operands

Overview:
- Input-side wrapper for the sequential multiplier; the companion of the output wrapper, which holds the product until resultaccept.
- Accepts operand pairs from the host over a valid/ready handshake and queues them in a small FIFO.
- Issues one multiply at a time as a one-cycle start pulse with registered operands.
- Holds off the next issue until doneMul and then resultaccept have both been seen, so at most one product is in flight.

Parameters:
- WIDTH, 16, operand width; the product is 2*WIDTH (32 at default).
- DEPTH, 2, operand FIFO depth; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- invalid  input  1  host presents a valid operand pair.
- inA  input  WIDTH  operand A.
- inB  input  WIDTH  operand B.
- inready  output  1  FIFO can accept a pair this cycle.
- startMul  output  1  one-cycle start pulse to the multiplier.
- opA  output  WIDTH  registered operand A to the multiplier.
- opB  output  WIDTH  registered operand B to the multiplier.
- doneMul  input  1  multiplier finished (level, sampled).
- resultaccept  input  1  consumer took the product from the output wrapper.
- busy  output  1  a multiply is issued or its result is not yet accepted.
- pending  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is synchronous on clk when rst=1.
  - Outputs: startMul=0, opA=0, opB=0, busy=0, pending=0, inready=1.
  - State goes to IDLE; FIFO pointers are cleared and queued pairs are discarded.
  - Reset mid-operation abandons any in-flight multiply; doneMul/resultaccept arriving later in IDLE are ignored.
- Push: at an edge with invalid&inready, {inA,inB} is written at the write pointer and occupancy increments.
  - inready = (pending < DEPTH), decoded from registered occupancy with no combinational path from invalid.
  - invalid while inready=0 is ignored; the host must hold data until accepted.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; a full/empty distinction comes only from the occupancy counter.
- FSM states: IDLE, ISSUE, BUSY, HOLD.
  - IDLE: if pending≠0 at an edge → ISSUE. On that edge, opA/opB load from the FIFO head and the FIFO pops.
  - ISSUE: startMul=1 for exactly this one cycle. The next edge always → BUSY. doneMul is ignored in ISSUE.
  - BUSY: if doneMul=1 → HOLD; otherwise stay.
  - HOLD: if resultaccept=1, go → ISSUE when pending≠0 (pop and load opA/opB on the same edge), else → IDLE. If resultaccept=0, stay.
- Latency: a pair pushed at edge k reaches an empty, idle block as IDLE→ISSUE at edge k+1, so startMul is high in cycle k+1..k+2.
- Back-to-back issue: HOLD→ISSUE directly, with no IDLE bubble.
- opA/opB stay stable from the load edge until the next load, including through BUSY and HOLD.
- busy = (state ≠ IDLE).
- Simultaneous push and pop on the same edge: occupancy is unchanged, both pointers advance, and the written entry is not the one popped.
  - At pending=DEPTH, push is impossible (inready=0), so a pop-only edge frees a slot and inready rises the next cycle.
  - At pending=0, there is no pop; a push in IDLE is issued on the following edge, with no fall-through.
- Arithmetic: occupancy +1 on push-only, −1 on pop-only, unchanged on both or neither; it never exceeds DEPTH or goes below 0.

Test Plan:
- Reset then single op: push inA=3, inB=5 at edge 1 → startMul high for exactly one cycle after edge 2 with opA=3, opB=5. Assert doneMul → HOLD; assert resultaccept → IDLE, busy=0, pending=0.
- Fill FIFO while busy: issue 7×9, then push 2×4 and 6×6 during BUSY → pending=2, inready=0. A third invalid is ignored (pending stays 2).
- Back-to-back: after 7×9 is accepted, the next edge → ISSUE with opA=2, opB=4 (no IDLE cycle) and pending=1. Then 6×6 is issued after its own accept, with order preserved.
- Simultaneous push/pop: with pending=1 in HOLD, assert resultaccept together with invalid (inA=10, inB=11) → pending stays 1, opA=head value, and the 10×11 entry is issued later.
- Pointer wrap: push and issue 5 pairs in sequence (DEPTH=2) → every opA/opB pair matches push order and pending returns to 0.
- Reset mid-operation: rst in BUSY with pending=1 → next cycle state IDLE, pending=0, opA=opB=0, inready=1. A later doneMul/resultaccept produces no startMul.

Source files
------------

// File: rtl/wrap_in_operands.sv
// Input-side wrapper for the sequential multiplier: queues operand pairs and issues
// one multiply at a time, waiting for doneMul and then resultaccept before the next.
module wrap_in_operands #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     invalid,
    input  logic [WIDTH-1:0]         inA,
    input  logic [WIDTH-1:0]         inB,
    output logic                     inready,
    output logic                     startMul,
    output logic [WIDTH-1:0]         opA,
    output logic [WIDTH-1:0]         opB,
    input  logic                     doneMul,
    input  logic                     resultaccept,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [PW:0]      r_count;
    logic [WIDTH-1:0] r_memA [DEPTH];
    logic [WIDTH-1:0] r_memB [DEPTH];
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    // Full/empty comes only from the occupancy counter; pointers just wrap.
    assign w_empty = (r_count == '0);
    assign inready = (r_count < FULL);
    assign w_push  = invalid & inready;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next = ISSUE;
                    w_pop  = 1'b1;
                end
            end
            ISSUE: w_next = BUSY;
            BUSY: begin
                if (doneMul) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                if (resultaccept) begin
                    if (!w_empty) begin
                        w_next = ISSUE;
                        w_pop  = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; reset discards entries by clearing the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memA[r_wrPtr] <= inA;
            r_memB[r_wrPtr] <= inB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opA <= '0;
            r_opB <= '0;
        end else if (w_pop) begin
            r_opA <= r_memA[r_rdPtr];
            r_opB <= r_memB[r_rdPtr];
        end
    end

    assign startMul = (r_state == ISSUE);
    assign busy     = (r_state != IDLE);
    assign opA      = r_opA;
    assign opB      = r_opB;
    assign pending  = r_count;

endmodule

// File: tb/tb_wrap_in_operands.sv
// Self-checking bench for wrap_in_operands: a hand-derived vector table, randomized
// traffic against a queue-based reference model, and a bounded-wait issue sequence.
module tb_wrap_in_operands;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             invalid;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             inready;
    logic             startMul;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             doneMul;
    logic             resultaccept;
    logic             busy;
    logic [1:0]       pending;

    int checks = 0;
    int errors = 0;

    wrap_in_operands #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .invalid(invalid), .inA(inA), .inB(inB),
        .inready(inready), .startMul(startMul), .opA(opA), .opB(opB),
        .doneMul(doneMul), .resultaccept(resultaccept), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    typedef struct {
        logic             rst;
        logic             inv;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             d;
        logic             acc;
        logic             eStart;
        logic [WIDTH-1:0] eA;
        logic [WIDTH-1:0] eB;
        logic             eBusy;
        logic [1:0]       ePend;
        logic             eRdy;
    } vec_t;

    // Reference model: queued pairs plus "a product is in flight" bookkeeping.
    pair_t            mQ[$];
    bit               mActive;
    bit               mStart;
    bit               mDone;
    logic [WIDTH-1:0] mOpA;
    logic [WIDTH-1:0] mOpB;

    function automatic vec_t mk(input logic r, input logic v, input int a, input int b,
                                input logic d, input logic acc, input logic eS,
                                input int eA, input int eB, input logic eBusy,
                                input int eP, input logic eR);
        vec_t t;
        t.rst = r; t.inv = v; t.a = WIDTH'(a); t.b = WIDTH'(b);
        t.d = d; t.acc = acc; t.eStart = eS; t.eA = WIDTH'(eA); t.eB = WIDTH'(eB);
        t.eBusy = eBusy; t.ePend = 2'(eP); t.eRdy = eR;
        return t;
    endfunction

    task automatic modelStep(input logic r, input logic v, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic d, input logic acc);
        int    size0;
        bit    doPush;
        bit    doPop;
        bit    startOld;
        pair_t p;
        if (r) begin
            mQ.delete();
            mActive = 0; mStart = 0; mDone = 0; mOpA = '0; mOpB = '0;
            return;
        end
        size0    = mQ.size();
        doPush   = v && (size0 < DEPTH);
        startOld = mStart;
        doPop    = (size0 > 0) && (!mActive || (mDone && acc));
        if (doPop) begin
            p = mQ.pop_front();
            mOpA = p.a; mOpB = p.b;
            mActive = 1; mStart = 1; mDone = 0;
        end else begin
            mStart = 0;
            if (mActive) begin
                if (mDone && acc) mActive = 0;
                else if (!startOld && d) mDone = 1;
            end
        end
        if (doPush) begin
            p.a = a; p.b = b;
            mQ.push_back(p);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic d, input logic acc);
        rst = r; invalid = v; inA = a; inB = b; doneMul = d; resultaccept = acc;
        modelStep(r, v, a, b, d, acc);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAgainstModel(input int cyc);
        string tag;
        tag = $sformatf("rnd%0d", cyc);
        checkOutput({tag, ".startMul"}, 32'(startMul), 32'(mStart));
        checkOutput({tag, ".opA"},      32'(opA),      32'(mOpA));
        checkOutput({tag, ".opB"},      32'(opB),      32'(mOpB));
        checkOutput({tag, ".busy"},     32'(busy),     32'(mActive));
        checkOutput({tag, ".pending"},  32'(pending),  32'(mQ.size()));
        checkOutput({tag, ".inready"},  32'(inready),  32'(mQ.size() < DEPTH));
    endtask

    vec_t vecs[30];

    initial begin
        bit seen;
        rst = 1'b1; invalid = 1'b0; inA = '0; inB = '0; doneMul = 1'b0; resultaccept = 1'b0;

        //               rst v  a   b   d  acc   st  oA  oB  bsy pnd rdy
        vecs[0]  = mk(1, 0,  0,  0, 0, 0,   0,  0,  0, 0,  0, 1);
        vecs[1]  = mk(0, 1,  3,  5, 0, 0,   0,  0,  0, 0,  1, 1);
        vecs[2]  = mk(0, 0,  0,  0, 0, 0,   1,  3,  5, 1,  0, 1);
        vecs[3]  = mk(0, 0,  0,  0, 0, 0,   0,  3,  5, 1,  0, 1);
        vecs[4]  = mk(0, 0,  0,  0, 1, 0,   0,  3,  5, 1,  0, 1);
        vecs[5]  = mk(0, 0,  0,  0, 0, 1,   0,  3,  5, 0,  0, 1);
        vecs[6]  = mk(0, 1,  7,  9, 0, 0,   0,  3,  5, 0,  1, 1);
        vecs[7]  = mk(0, 0,  0,  0, 1, 0,   1,  7,  9, 1,  0, 1);
        vecs[8]  = mk(0, 1,  2,  4, 1, 0,   0,  7,  9, 1,  1, 1);
        vecs[9]  = mk(0, 1,  6,  6, 0, 0,   0,  7,  9, 1,  2, 0);
        vecs[10] = mk(0, 1,  8,  8, 0, 0,   0,  7,  9, 1,  2, 0);
        vecs[11] = mk(0, 1,  8,  8, 0, 1,   0,  7,  9, 1,  2, 0);
        vecs[12] = mk(0, 0,  0,  0, 1, 0,   0,  7,  9, 1,  2, 0);
        vecs[13] = mk(0, 0,  0,  0, 0, 1,   1,  2,  4, 1,  1, 1);
        vecs[14] = mk(0, 0,  0,  0, 0, 0,   0,  2,  4, 1,  1, 1);
        vecs[15] = mk(0, 0,  0,  0, 1, 0,   0,  2,  4, 1,  1, 1);
        vecs[16] = mk(0, 1, 10, 11, 0, 1,   1,  6,  6, 1,  1, 1);
        vecs[17] = mk(0, 0,  0,  0, 0, 0,   0,  6,  6, 1,  1, 1);
        vecs[18] = mk(0, 0,  0,  0, 1, 0,   0,  6,  6, 1,  1, 1);
        vecs[19] = mk(0, 0,  0,  0, 0, 1,   1, 10, 11, 1,  0, 1);
        vecs[20] = mk(0, 0,  0,  0, 0, 0,   0, 10, 11, 1,  0, 1);
        vecs[21] = mk(0, 0,  0,  0, 1, 0,   0, 10, 11, 1,  0, 1);
        vecs[22] = mk(0, 0,  0,  0, 0, 1,   0, 10, 11, 0,  0, 1);
        vecs[23] = mk(0, 1, 12, 13, 0, 0,   0, 10, 11, 0,  1, 1);
        vecs[24] = mk(0, 1, 14, 15, 0, 0,   1, 12, 13, 1,  1, 1);
        vecs[25] = mk(0, 0,  0,  0, 0, 0,   0, 12, 13, 1,  1, 1);
        vecs[26] = mk(1, 0,  0,  0, 0, 0,   0,  0,  0, 0,  0, 1);
        vecs[27] = mk(0, 0,  0,  0, 1, 0,   0,  0,  0, 0,  0, 1);
        vecs[28] = mk(0, 0,  0,  0, 0, 1,   0,  0,  0, 0,  0, 1);
        vecs[29] = mk(0, 0,  0,  0, 0, 0,   0,  0,  0, 0,  0, 1);

        $display("[TB] directed vector table");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].inv, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].acc);
            checkOutput($sformatf("vec%0d.startMul", i), 32'(startMul), 32'(vecs[i].eStart));
            checkOutput($sformatf("vec%0d.opA", i),      32'(opA),      32'(vecs[i].eA));
            checkOutput($sformatf("vec%0d.opB", i),      32'(opB),      32'(vecs[i].eB));
            checkOutput($sformatf("vec%0d.busy", i),     32'(busy),     32'(vecs[i].eBusy));
            checkOutput($sformatf("vec%0d.pending", i),  32'(pending),  32'(vecs[i].ePend));
            checkOutput($sformatf("vec%0d.inready", i),  32'(inready),  32'(vecs[i].eRdy));
        end

        $display("[TB] randomized traffic against reference model");
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        checkAgainstModel(-1);
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 1) == 1),
                          WIDTH'($urandom), WIDTH'($urandom),
                          ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 9) < 3));
            checkAgainstModel(c);
        end

        $display("[TB] bounded wait for issue after reset");
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0);
        seen = 0;
        for (int w = 0; w < 8 && !seen; w++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            seen = startMul;
        end
        checkOutput("waitStart", 32'(seen), 32'd1);
        checkOutput("waitStart.opA", 32'(opA), 32'h1234);
        checkOutput("waitStart.opB", 32'(opB), 32'h5678);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("waitStart.busyAfter", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
